// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D-cache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Round-robin winner selection between the I-cache and D-cache requesters.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic any_req,
  output logic pick_d
);

  // On contention the side not granted last wins; a lone requester always wins.
  always_comb begin
    any_req = i_req | d_req;
    pick_d  = d_req & (~i_req | ~last_d);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single line-wide memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d
);

  arb_state_t        state_q, state_d;
  logic              grant_d_q;
  logic              op_read_q, op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req, pick_d;

  mem_arb_pick u_pick (
    .i_req   (i_mem_read),
    .d_req   (d_mem_read | d_mem_write),
    .last_d  (grant_d_q),
    .any_req (any_req),
    .pick_d  (pick_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_d_q  <= 1'b0;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        grant_d_q  <= pick_d;
        // A D-cache read+write collision is serviced as the write-back.
        op_write_q <= pick_d & d_mem_write;
        op_read_q  <= pick_d ? (d_mem_read & ~d_mem_write) : 1'b1;
        addr_q     <= pick_d ? d_mem_addr : i_mem_addr;
        wdata_q    <= pick_d ? d_mem_wdata : '0;
      end
      if (state_q == BUSY && mem_ready) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = BUSY;
      end
      BUSY: begin
        mem_read  = op_read_q;
        mem_write = op_write_q;
        if (mem_ready) state_d = RESP;
      end
      RESP: begin
        i_mem_ready = ~grant_d_q;
        d_mem_ready = grant_d_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_mem_rdata = rdata_q;
  assign d_mem_rdata = rdata_q;
  assign grant_d     = grant_d_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, giving the cache-line address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, giving the cache-line data width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- i_mem_read  in  1  I-cache line refill request.
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_rdata  out  DATA_W  refill data returned to the I-cache.
- i_mem_ready  out  1  I-cache transaction complete.
- d_mem_read  in  1  D-cache refill request.
- d_mem_write  in  1  D-cache write-back request.
- d_mem_addr  in  ADDR_W  D-cache line address.
- d_mem_wdata  in  DATA_W  D-cache write-back line.
- d_mem_rdata  out  DATA_W  refill data returned to the D-cache.
- d_mem_ready  out  1  D-cache transaction complete.
- mem_read  out  1  shared memory read strobe.
- mem_write  out  1  shared memory write strobe.
- mem_addr  out  ADDR_W  shared memory line address.
- mem_wdata  out  DATA_W  shared memory write line.
- mem_rdata  in  DATA_W  shared memory read line.
- mem_ready  in  1  shared memory completion.
- grant_d  out  1  current/last owner (1 = D-cache).

Function
REQ-005 FSM states SHALL be IDLE, BUSY, RESP.
REQ-006 IDLE: if any request is pending, the arbiter SHALL pick a winner, register the winner's op, address and wdata, and go to BUSY; otherwise it stays in IDLE.
REQ-007 A request is pending when i_mem_read=1 (I-cache) or (d_mem_read|d_mem_write)=1 (D-cache).
REQ-008 On simultaneous I and D requests, the winner SHALL be the requester not granted last (round-robin on grant_d); a single pending requester wins outright.
REQ-009 D-cache with both read and write asserted SHALL be treated as a write.
REQ-010 BUSY: mem_read/mem_write/mem_addr/mem_wdata SHALL be driven from the registered values and held constant until mem_ready=1, at which point the arbiter captures mem_rdata and goes to RESP.
REQ-011 mem_read and mem_write SHALL be 0 in IDLE and RESP.
REQ-012 RESP: the arbiter SHALL assert exactly one cycle of ready to the winner, with rdata equal to the captured line, and then go to IDLE.
REQ-013 Latency: the first memory strobe SHALL appear 1 cycle after the request is sampled; ready SHALL appear 1 cycle after mem_ready.
REQ-014 The loser's ready SHALL stay 0; a requester dropping its request mid-BUSY SHALL NOT abort the memory transaction.
REQ-015 A requester still asserting its request in IDLE after RESP SHALL be treated as a new request.
REQ-016 Round-robin SHALL bound the wait for any request to at most one foreign transaction.
REQ-017 i_mem_rdata and d_mem_rdata SHALL both carry the captured line, qualified only by their ready.
REQ-018 grant_d SHALL update only in IDLE when a winner is chosen.

Reset
REQ-019 When rst=1 at an edge, state SHALL go to IDLE and all outputs, registered address/data and grant_d SHALL go to 0, including mid-BUSY.
REQ-020 After a reset taken during BUSY or RESP, no ready pulse SHALL be emitted for the aborted transaction.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum and the ADDR_W/DATA_W defaults.
REQ-022 The round-robin winner selection SHALL be a combinational sub-module named mem_arb_pick; all registers SHALL stay in mem_arbiter.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- I read addr 0x0000010 alone, mem_ready after 4 cycles, rdata 0xA5..A5 -> mem_read=1 for 4 cycles, then i_mem_ready pulse with i_mem_rdata=0xA5..A5, d_mem_ready=0.
- D write addr 0x0000020, wdata 0x1234...; mem_ready after 3 cycles -> mem_write=1 with exact address/data, then d_mem_ready pulse.
- I and D request the same cycle after reset (grant_d=0) -> D served first, then I; no ready overlap.
- D read+write both asserted -> mem_write=1, mem_read=0.
- rst=1 during the 2nd BUSY cycle -> next cycle all outputs 0, no ready pulse; a new I request is then served normally.
- Back-to-back D requests with I pending -> order D, I, D.
